// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: ID-side fields, MEM/WB forwarding sources,
// hazard controls and EX-side outputs, with master/slave views.
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RAW-1:0]  id_rs1;
  logic [RAW-1:0]  id_rs2;
  logic [RAW-1:0]  id_rd;
  logic [2:0]      id_alu_sl;
  logic            id_a_src;
  logic            id_b_src;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            mem_reg_write;
  logic [RAW-1:0]  mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_reg_write;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            ex_valid;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [2:0]      alu_sl;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [RAW-1:0]  ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            load_use_hazard;

  modport master (
    output stall, flush, id_valid, id_pc,
    output id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_alu_sl,
    output id_a_src, id_b_src, id_reg_write,
    output id_mem_read, id_mem_write,
    output mem_reg_write, mem_rd, mem_result,
    output wb_reg_write, wb_rd, wb_result,
    input  ex_valid, alu_in1, alu_in2, alu_sl,
    input  ex_store_data, ex_pc, ex_imm, ex_rd,
    input  ex_reg_write, ex_mem_read,
    input  ex_mem_write, load_use_hazard
  );

  modport slave (
    input  stall, flush, id_valid, id_pc,
    input  id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_alu_sl,
    input  id_a_src, id_b_src, id_reg_write,
    input  id_mem_read, id_mem_write,
    input  mem_reg_write, mem_rd, mem_result,
    input  wb_reg_write, wb_rd, wb_result,
    output ex_valid, alu_in1, alu_in2, alu_sl,
    output ex_store_data, ex_pc, ex_imm, ex_rd,
    output ex_reg_write, ex_mem_read,
    output ex_mem_write, load_use_hazard
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detect.
// Ports: clk, rst (sync, active high), bus (slave view of the stage bus).
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  id_ex_operand_stage_if.slave  bus
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [2:0]      sl;
    logic            a_src;
    logic            b_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_t;

  id_ex_t          ex_q;
  id_ex_t          ex_d;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  // Side-effect controls gated by valid so bubbles never write.
  always_comb begin
    ex_d           = '0;
    ex_d.valid     = bus.id_valid;
    ex_d.pc        = bus.id_pc;
    ex_d.rs1_data  = bus.id_rs1_data;
    ex_d.rs2_data  = bus.id_rs2_data;
    ex_d.imm       = bus.id_imm;
    ex_d.rs1       = bus.id_rs1;
    ex_d.rs2       = bus.id_rs2;
    ex_d.rd        = bus.id_rd;
    ex_d.sl        = bus.id_alu_sl;
    ex_d.a_src     = bus.id_a_src;
    ex_d.b_src     = bus.id_b_src;
    ex_d.reg_write = bus.id_reg_write & bus.id_valid;
    ex_d.mem_read  = bus.id_mem_read & bus.id_valid;
    ex_d.mem_write = bus.id_mem_write & bus.id_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (bus.flush) begin
      ex_q <= '0;
    end else if (!bus.stall) begin
      ex_q <= ex_d;
    end
  end

  // MEM wins over WB; x0 is never forwarded.
  always_comb begin
    fwd1 = ex_q.rs1_data;
    if (bus.mem_reg_write && bus.mem_rd == ex_q.rs1
        && ex_q.rs1 != '0) begin
      fwd1 = bus.mem_result;
    end else if (bus.wb_reg_write && bus.wb_rd == ex_q.rs1
                 && ex_q.rs1 != '0) begin
      fwd1 = bus.wb_result;
    end
  end

  always_comb begin
    fwd2 = ex_q.rs2_data;
    if (bus.mem_reg_write && bus.mem_rd == ex_q.rs2
        && ex_q.rs2 != '0) begin
      fwd2 = bus.mem_result;
    end else if (bus.wb_reg_write && bus.wb_rd == ex_q.rs2
                 && ex_q.rs2 != '0) begin
      fwd2 = bus.wb_result;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.alu_in1       = ex_q.a_src ? ex_q.pc : fwd1;
  assign bus.alu_in2       = ex_q.b_src ? ex_q.imm : fwd2;
  assign bus.alu_sl        = ex_q.sl;
  assign bus.ex_store_data = fwd2;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;

  assign bus.load_use_hazard = ex_q.valid & ex_q.mem_read
    & (ex_q.rd != '0) & bus.id_valid
    & ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage.
// Expectations are queued with stimulus and drained after each settle.
module tb_id_ex_operand_stage;
  localparam int S_VALID = 0;
  localparam int S_IN1   = 1;
  localparam int S_IN2   = 2;
  localparam int S_SL    = 3;
  localparam int S_STORE = 4;
  localparam int S_RW    = 5;
  localparam int S_MR    = 6;
  localparam int S_MW    = 7;
  localparam int S_HAZ   = 8;
  localparam int S_PC    = 9;
  localparam int S_RD    = 10;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  id_ex_operand_stage_if bus_if ();

  id_ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] peek(int sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      S_VALID: v = {31'd0, bus_if.ex_valid};
      S_IN1:   v = bus_if.alu_in1;
      S_IN2:   v = bus_if.alu_in2;
      S_SL:    v = {29'd0, bus_if.alu_sl};
      S_STORE: v = bus_if.ex_store_data;
      S_RW:    v = {31'd0, bus_if.ex_reg_write};
      S_MR:    v = {31'd0, bus_if.ex_mem_read};
      S_MW:    v = {31'd0, bus_if.ex_mem_write};
      S_HAZ:   v = {31'd0, bus_if.load_use_hazard};
      S_PC:    v = bus_if.ex_pc;
      S_RD:    v = {27'd0, bus_if.ex_rd};
      default: v = 'x;
    endcase
    return v;
  endfunction

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int sel, logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, peek(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(
    input logic        v,
    input logic [31:0] pc,
    input logic [31:0] r1d,
    input logic [31:0] r2d,
    input logic [31:0] imm,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [2:0]  sl,
    input logic        a,
    input logic        b,
    input logic        rw,
    input logic        mr,
    input logic        mw
  );
    bus_if.id_valid     = v;
    bus_if.id_pc        = pc;
    bus_if.id_rs1_data  = r1d;
    bus_if.id_rs2_data  = r2d;
    bus_if.id_imm       = imm;
    bus_if.id_rs1       = rs1;
    bus_if.id_rs2       = rs2;
    bus_if.id_rd        = rd;
    bus_if.id_alu_sl    = sl;
    bus_if.id_a_src     = a;
    bus_if.id_b_src     = b;
    bus_if.id_reg_write = rw;
    bus_if.id_mem_read  = mr;
    bus_if.id_mem_write = mw;
  endtask

  task automatic set_fwd(
    input logic        mw,
    input logic [4:0]  mrd,
    input logic [31:0] mres,
    input logic        ww,
    input logic [4:0]  wrd,
    input logic [31:0] wres
  );
    bus_if.mem_reg_write = mw;
    bus_if.mem_rd        = mrd;
    bus_if.mem_result    = mres;
    bus_if.wb_reg_write  = ww;
    bus_if.wb_rd         = wrd;
    bus_if.wb_result     = wres;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.stall = 1'b0;
    bus_if.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_id(1'b1, $urandom, $urandom, $urandom, $urandom,
             5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom),
             1'b1, 1'b1, 1'b1);
      set_fwd(1'b1, 5'($urandom), $urandom,
              1'b1, 5'($urandom), $urandom);
      tick();
    end
    push("rst_valid", S_VALID, 0);
    push("rst_sl", S_SL, 0);
    push("rst_rw", S_RW, 0);
    push("rst_mr", S_MR, 0);
    push("rst_mw", S_MW, 0);
    push("rst_in1", S_IN1, 0);
    push("rst_in2", S_IN2, 0);
    push("rst_haz", S_HAZ, 0);
    drain();

    rst = 1'b0;
    set_fwd(1'b0, 0, 0, 1'b0, 0, 0);

    // plain register-register op
    set_id(1, 32'h40, 5, 7, 0, 1, 2, 3, 3'b001, 0, 0, 1, 0, 0);
    tick();
    push("plain_in1", S_IN1, 5);
    push("plain_in2", S_IN2, 7);
    push("plain_sl", S_SL, 1);
    push("plain_valid", S_VALID, 1);
    push("plain_rw", S_RW, 1);
    push("plain_pc", S_PC, 32'h40);
    push("plain_rd", S_RD, 3);
    drain();

    // AUIPC form, undefined op code passes through
    set_id(1, 32'h100, 9, 9, 32'h1000, 1, 2, 3, 3'b111,
           1, 1, 1, 0, 0);
    tick();
    push("auipc_in1", S_IN1, 32'h100);
    push("auipc_in2", S_IN2, 32'h1000);
    push("sl_111", S_SL, 7);
    drain();

    // forwarding priority on rs1=3, rs2=8
    set_id(1, 0, 32'h11, 32'h12, 0, 3, 8, 9, 0, 0, 0, 1, 0, 0);
    tick();
    set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
    settle();
    push("fwd_mem", S_IN1, 32'hAA);
    push("fwd_rs2_none", S_IN2, 32'h12);
    drain();
    set_fwd(0, 3, 32'hAA, 1, 3, 32'hBB);
    settle();
    push("fwd_wb", S_IN1, 32'hBB);
    drain();
    set_fwd(0, 3, 32'hAA, 1, 8, 32'hCC);
    settle();
    push("fwd_wb_rs2", S_IN2, 32'hCC);
    push("fwd_wb_st", S_STORE, 32'hCC);
    push("fwd_rs1_reg", S_IN1, 32'h11);
    drain();

    // x0 never forwarded
    set_id(1, 0, 32'h22, 32'h23, 0, 0, 0, 9, 0, 0, 0, 1, 0, 0);
    set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
    tick();
    push("x0_in1", S_IN1, 32'h22);
    push("x0_in2", S_IN2, 32'h23);
    drain();
    set_fwd(0, 0, 0, 0, 0, 0);

    // stall holds A while B waits in ID
    set_id(1, 32'hA0, 32'h41, 32'h42, 0, 10, 11, 5,
           3'b010, 0, 0, 1, 0, 0);
    tick();
    set_id(1, 32'hB0, 32'h51, 32'h52, 0, 12, 13, 6,
           3'b100, 0, 0, 1, 1, 0);
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      push("stall_in1", S_IN1, 32'h41);
      push("stall_sl", S_SL, 2);
      push("stall_pc", S_PC, 32'hA0);
      push("stall_mr", S_MR, 0);
      drain();
    end
    // held operand picks up a new producer
    set_fwd(1, 10, 32'h77, 0, 0, 0);
    settle();
    push("stall_fwd", S_IN1, 32'h77);
    drain();
    set_fwd(0, 0, 0, 0, 0, 0);

    // flush beats stall
    bus_if.flush = 1'b1;
    tick();
    push("flush_valid", S_VALID, 0);
    push("flush_rw", S_RW, 0);
    push("flush_mr", S_MR, 0);
    push("flush_sl", S_SL, 0);
    push("flush_in1", S_IN1, 0);
    drain();
    bus_if.flush = 1'b0;
    bus_if.stall = 1'b0;

    // invalid ID never produces side effects
    set_id(0, 0, 1, 2, 0, 1, 2, 3, 0, 0, 0, 1, 1, 1);
    tick();
    push("inv_valid", S_VALID, 0);
    push("inv_rw", S_RW, 0);
    push("inv_mr", S_MR, 0);
    push("inv_mw", S_MW, 0);
    drain();

    // load-use hazard
    set_id(1, 0, 0, 0, 0, 1, 2, 4, 0, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 9, 4, 7, 0, 0, 0, 1, 0, 0);
    settle();
    push("lu_rs2", S_HAZ, 1);
    drain();
    bus_if.id_rs1 = 4;
    bus_if.id_rs2 = 9;
    settle();
    push("lu_rs1", S_HAZ, 1);
    drain();
    bus_if.id_valid = 0;
    settle();
    push("lu_id_inv", S_HAZ, 0);
    drain();
    bus_if.flush = 1'b1;
    bus_if.id_valid = 1;
    tick();
    bus_if.flush = 1'b0;
    push("lu_flush", S_HAZ, 0);
    drain();
    set_id(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 0);
    settle();
    push("lu_rd0", S_HAZ, 0);
    drain();
    // reset while hazard active
    set_id(1, 0, 0, 0, 0, 1, 2, 4, 0, 0, 1, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 4, 0, 7, 0, 0, 0, 1, 0, 0);
    bus_if.stall = 1'b1;
    settle();
    push("lu_pre_rst", S_HAZ, 1);
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.stall = 1'b0;
    push("lu_rst", S_HAZ, 0);
    push("lu_rst_valid", S_VALID, 0);
    drain();

    // store: in2 takes imm, store data forwarded from MEM
    set_id(1, 0, 0, 32'h99, 8, 1, 6, 0, 0, 0, 1, 0, 0, 1);
    tick();
    set_fwd(1, 6, 32'h1234, 0, 0, 0);
    settle();
    push("st_in2", S_IN2, 8);
    push("st_data", S_STORE, 32'h1234);
    push("st_mw", S_MW, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage directly upstream of the ALU. It latches decoded operands and control each cycle and resolves RAW hazards by forwarding MEM/WB results. It drives the ALU's in1/in2/sl and passes store data and control downstream. It also flags load-use hazards to the hazard unit.

Parameters:
XLEN, 32, datapath width
RAW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold stage contents
flush  in  1  insert bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  regfile read 1
id_rs2_data  in  XLEN  regfile read 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  RAW  source index 1
id_rs2  in  RAW  source index 2
id_rd  in  RAW  destination index
id_alu_sl  in  3  ALU op code (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU)
id_a_src  in  1  1: in1=PC, 0: in1=rs1
id_b_src  in  1  1: in2=imm, 0: in2=rs2
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
mem_reg_write  in  1  MEM-stage instruction writes rd
mem_rd  in  RAW  MEM-stage rd
mem_result  in  XLEN  MEM-stage ALU result
wb_reg_write  in  1  WB-stage instruction writes rd
wb_rd  in  RAW  WB-stage rd
wb_result  in  XLEN  WB-stage writeback value
ex_valid  out  1  stage holds a real instruction
alu_in1  out  XLEN  ALU operand 1
alu_in2  out  XLEN  ALU operand 2
alu_sl  out  3  ALU op select
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_pc  out  XLEN  registered PC
ex_imm  out  XLEN  registered immediate
ex_rd  out  RAW  registered rd
ex_reg_write  out  1  gated reg_write
ex_mem_read  out  1  gated mem_read
ex_mem_write  out  1  gated mem_write
load_use_hazard  out  1  ID instruction needs the load result currently in EX

Behaviour:
- Register update priority per rising edge: rst > flush > stall > load.
- rst: every registered field = 0. ex_valid=0, alu_sl=000, all control 0, all data/index fields 0.
- flush: same values as reset (bubble). flush overrides a simultaneous stall.
- stall (no flush): all registered fields hold.
- load: every field takes its id_* input. ex_valid=id_valid. reg_write/mem_read/mem_write are ANDed with id_valid, so an invalid ID never produces side effects.
- Latency: ID inputs appear on registered outputs 1 cycle later. Forwarding and muxes are combinational from registered fields plus mem_*/wb_* inputs, with zero added latency.
- Forwarding for each source (rs = registered rs1 or rs2):
  - If mem_reg_write, mem_rd==rs and rs!=0, use mem_result.
  - Else if wb_reg_write, wb_rd==rs and rs!=0, use wb_result.
  - Else use the registered regfile data.
  - MEM takes priority over WB. x0 is never forwarded.
- Forwarding is re-evaluated every cycle, including while stalled, so held operands pick up newly arriving producers.
- alu_in1 = a_src ? ex_pc : fwd_rs1. alu_in2 = b_src ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2, regardless of b_src.
- alu_sl passes through unchanged. Codes 111 and undefined codes are forwarded as-is.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). Combinational.
- The block never self-stalls. The external hazard unit drives stall upstream and flush here.
- Reset mid-stall or mid-hazard: the stage empties next edge and load_use_hazard drops to 0.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> after the edge ex_valid=0, alu_sl=000, ex_reg_write=ex_mem_read=ex_mem_write=0, alu_in1=alu_in2=0 (no forwarding active).
- Plain load: id_valid=1, rs1_data=5, rs2_data=7, sl=001, srcs 0, no forwarding -> next cycle alu_in1=5, alu_in2=7, alu_sl=001. With the AUIPC form (id_pc=0x100, a_src=1, b_src=1, imm=0x1000) -> alu_in1=0x100, alu_in2=0x1000.
- Forwarding priority: EX rs1=3.
  - mem_rd=3, mem_result=0xAA, wb_rd=3, wb_result=0xBB, both writes=1 -> alu_in1=0xAA.
  - Drop mem_reg_write -> 0xBB.
  - With rs1=0, same producers -> the registered data is used.
- Stall/flush: load instr A, then stall=1 with new ID instr B -> outputs stay A for 3 cycles.
  - stall=1 and flush=1 together -> bubble, ex_valid=0, controls 0.
  - id_valid=0 with id_reg_write=1 -> ex_reg_write=0.
- Load-use: EX holds a load (mem_read=1, rd=4), ID has id_rs2=4, id_valid=1 -> load_use_hazard=1.
  - rd=0 -> 0.
  - After flush -> 0.
- Store data: EX store with b_src=1, imm=8, rs2=6, mem_rd=6, mem_result=0x1234 -> alu_in2=8, ex_store_data=0x1234.
